// File: rtl/cache_mem_bridge_if.sv
// Cache-side request port and word-wide memory bus of the cache/memory bridge.
// slave = the bridge's view; master = the cache plus memory driving it.
interface cache_mem_bridge_if #(
   parameter int BLOCK_SIZE = 16
);
   logic                    req_re;
   logic                    req_we;
   logic [31:0]             req_addr;
   logic [BLOCK_SIZE*8-1:0] req_wdata;
   logic                    req_ready;
   logic                    req_done;
   logic [BLOCK_SIZE*8-1:0] req_rdata;
   logic                    mem_valid;
   logic                    mem_we;
   logic [31:0]             mem_addr;
   logic [31:0]             mem_wdata;
   logic                    mem_ready;
   logic [31:0]             mem_rdata;

   modport slave (
      input  req_re, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
      output req_ready, req_done, req_rdata, mem_valid, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_re, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
      input  req_ready, req_done, req_rdata, mem_valid, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_mem_bridge.sv
// Splits one whole-block cache fill/writeback into ascending 32-bit beats
// and reassembles read beats into a block for the cache.
module cache_mem_bridge #(
   parameter int BLOCK_SIZE = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   cache_mem_bridge_if.slave bus
);
   localparam int WORDS        = BLOCK_SIZE / 4;
   localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
   localparam int CNT_W        = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next, cnt_inc;
   logic [31:0]            base_reg, base_next;
   logic [WORDS-1:0][31:0] wblock_reg, wblock_next;
   logic [WORDS-1:0][31:0] rdata_reg, rdata_next;
   logic [WORDS-1:0][31:0] req_words;
   logic                   ready_reg, ready_next;
   logic                   done_reg, done_next;
   logic                   mem_valid_reg, mem_valid_next;
   logic                   mem_we_reg, mem_we_next;
   logic [31:0]            mem_addr_reg, mem_addr_next;
   logic [31:0]            mem_wdata_reg, mem_wdata_next;
   logic [31:0]            req_base;

   for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
      assign req_words[gi] = bus.req_wdata[32*gi +: 32];
   end

   assign req_base = {bus.req_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
   assign cnt_inc  = cnt_reg + CNT_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         base_reg      <= '0;
         wblock_reg    <= '0;
         rdata_reg     <= '0;
         ready_reg     <= 1'b1;
         done_reg      <= 1'b0;
         mem_valid_reg <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         base_reg      <= base_next;
         wblock_reg    <= wblock_next;
         rdata_reg     <= rdata_next;
         ready_reg     <= ready_next;
         done_reg      <= done_next;
         mem_valid_reg <= mem_valid_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      base_next      = base_reg;
      wblock_next    = wblock_reg;
      rdata_next     = rdata_reg;
      ready_next     = ready_reg;
      done_next      = 1'b0;
      mem_valid_next = mem_valid_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;

      case (state_reg)
         IDLE: begin
            if (bus.req_re || bus.req_we) begin
               // a write request wins when the cache raises both strobes
               state_next     = BURST;
               base_next      = req_base;
               wblock_next    = req_words;
               cnt_next       = '0;
               ready_next     = 1'b0;
               mem_valid_next = 1'b1;
               mem_we_next    = bus.req_we;
               mem_addr_next  = req_base;
               mem_wdata_next = req_words[0];
            end
         end
         BURST: begin
            if (mem_valid_reg && bus.mem_ready) begin
               if (!mem_we_reg) begin
                  rdata_next[cnt_reg] = bus.mem_rdata;
               end
               if (cnt_reg == CNT_W'(WORDS - 1)) begin
                  state_next     = IDLE;
                  cnt_next       = '0;
                  ready_next     = 1'b1;
                  done_next      = 1'b1;
                  mem_valid_next = 1'b0;
               end else begin
                  // block-aligned base, so the offset add never carries into the tag
                  cnt_next       = cnt_inc;
                  mem_addr_next  = base_reg + {{(30 - CNT_W){1'b0}}, cnt_inc, 2'b00};
                  mem_wdata_next = wblock_reg[cnt_inc];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.req_ready = ready_reg;
   assign bus.req_done  = done_reg;
   assign bus.req_rdata = rdata_reg;
   assign bus.mem_valid = mem_valid_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: table of block bursts plus hand-written
// sequences for back-to-back requests and reset mid-burst.
module tb_cache_mem_bridge;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cache_mem_bridge_if #(.BLOCK_SIZE(16)) bus ();

   cache_mem_bridge #(.BLOCK_SIZE(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // memory model: read data is the beat address scrambled with a constant
   assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5A5A5;

   typedef struct {
      logic         re;
      logic         we;
      logic [31:0]  addr;
      logic [127:0] wdata;
      int           stall;
      logic         exp_we;
      logic [31:0]  exp_base;
      logic [127:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full burst: request for one cycle, then per beat 'stall' cycles with
   // mem_ready low followed by one accepting cycle.
   task automatic run_burst(input int idx, input vec_t v);
      logic [127:0] wd;
      wd = v.wdata;
      @(posedge clk); #1;
      bus.req_re    = v.re;
      bus.req_we    = v.we;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      bus.req_re = 1'b0;
      bus.req_we = 1'b0;
      bus.req_wdata = ~v.wdata;
      for (int b = 0; b < 4; b++) begin
         for (int c = 0; c <= v.stall; c++) begin
            bus.mem_ready = (c == v.stall);
            @(negedge clk);
            chk("beat_valid", 128'(bus.mem_valid), 128'(1'b1));
            chk("beat_we",    128'(bus.mem_we),    128'(v.exp_we));
            chk("beat_addr",  128'(bus.mem_addr),  128'(v.exp_base + 32'(4 * b)));
            chk("beat_wdata", 128'(bus.mem_wdata), 128'(wd[32*b +: 32]));
            chk("busy_ready", 128'(bus.req_ready), 128'(1'b0));
            chk("busy_done",  128'(bus.req_done),  128'(1'b0));
            @(posedge clk); #1;
         end
      end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("end_done",  128'(bus.req_done),  128'(1'b1));
      chk("end_ready", 128'(bus.req_ready), 128'(1'b1));
      chk("end_valid", 128'(bus.mem_valid), 128'(1'b0));
      chk("end_rdata", bus.req_rdata, v.exp_rdata);
      @(negedge clk);
      chk("done_pulse", 128'(bus.req_done), 128'(1'b0));
      $display("txn %0d: re=%0b we=%0b addr=%h rdata=%h", idx, v.re, v.we, v.addr, bus.req_rdata);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 128'h0, 0, 1'b0, 32'h0000_1230,
                  128'hA5A5B799_A5A5B79D_A5A5B791_A5A5B795};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0080, 128'h44444444_33333333_22222222_11111111, 0, 1'b1,
                  32'h0000_0080, 128'hA5A5B799_A5A5B79D_A5A5B791_A5A5B795};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_2008, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 3, 1'b0,
                  32'h0000_2000, 128'hA5A585A9_A5A585AD_A5A585A1_A5A585A5};
      vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFF7, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 0, 1'b1,
                  32'hFFFF_FFF0, 128'hA5A585A9_A5A585AD_A5A585A1_A5A585A5};
      vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 128'h0, 1, 1'b0, 32'hFFFF_FFF0,
                  128'h5A5A5A59_5A5A5A5D_5A5A5A51_5A5A5A55};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0604, 128'h0, 0, 1'b0, 32'h0000_0600,
                  128'hA5A5A3A9_A5A5A3AD_A5A5A3A1_A5A5A3A5};

      rst           = 1'b1;
      bus.req_re    = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_mem_addr",  128'(bus.mem_addr),  128'(32'h0));
      chk("rst_mem_we",    128'(bus.mem_we),    128'(1'b0));
      chk("rst_mem_wdata", 128'(bus.mem_wdata), 128'(32'h0));
      for (int i = 0; i < 10; i++) begin
         chk("idle_ready", 128'(bus.req_ready), 128'(1'b1));
         chk("idle_valid", 128'(bus.mem_valid), 128'(1'b0));
         chk("idle_done",  128'(bus.req_done),  128'(1'b0));
         chk("idle_rdata", bus.req_rdata, 128'h0);
         @(negedge clk);
      end

      for (int i = 0; i < 5; i++) run_burst(i, vecs[i]);

      // back-to-back: a read presented during the done cycle starts next edge
      @(posedge clk); #1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h0000_0300;
      bus.req_wdata = 128'h88888888_77777777_66666666_55555555;
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.req_we = 1'b0;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk("b2b_w_addr",  128'(bus.mem_addr),  128'(32'h300 + 32'(4 * b)));
         chk("b2b_w_we",    128'(bus.mem_we),    128'(1'b1));
         chk("b2b_w_ready", 128'(bus.req_ready), 128'(1'b0));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("b2b_w_done", 128'(bus.req_done), 128'(1'b1));
      bus.req_re   = 1'b1;
      bus.req_addr = 32'h0000_0400;
      @(posedge clk); #1;
      bus.req_re = 1'b0;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk("b2b_r_valid", 128'(bus.mem_valid), 128'(1'b1));
         chk("b2b_r_we",    128'(bus.mem_we),    128'(1'b0));
         chk("b2b_r_addr",  128'(bus.mem_addr),  128'(32'h400 + 32'(4 * b)));
         chk("b2b_r_done",  128'(bus.req_done),  128'(1'b0));
         @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("b2b_r_end_done", 128'(bus.req_done), 128'(1'b1));
      chk("b2b_r_rdata", bus.req_rdata, 128'hA5A5A1A9_A5A5A1AD_A5A5A1A1_A5A5A1A5);
      $display("txn b2b: write 0x300 then read 0x400 rdata=%h", bus.req_rdata);

      // reset after two completed read beats
      @(posedge clk); #1;
      bus.req_re    = 1'b1;
      bus.req_addr  = 32'h0000_0500;
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.req_re = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("abort_valid", 128'(bus.mem_valid), 128'(1'b0));
      chk("abort_ready", 128'(bus.req_ready), 128'(1'b1));
      chk("abort_done",  128'(bus.req_done),  128'(1'b0));
      chk("abort_rdata", bus.req_rdata, 128'h0);
      @(negedge clk);
      chk("abort_done2", 128'(bus.req_done),  128'(1'b0));
      chk("abort_valid2", 128'(bus.mem_valid), 128'(1'b0));
      $display("txn abort: read 0x500 reset after 2 beats");
      run_burst(5, vecs[5]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
